// File: rtl/pp_frame_pkg.sv
// pp_frame_pkg: column geometry helpers and FSM state for the partial-product frame loader
package pp_frame_pkg;
  typedef enum logic [1:0] {FILL, SETTLE, RESULT} state_e;
  function automatic int col_height(input int i, input int n);
    return (i + 1 < 2 * n - 1 - i) ? i + 1 : 2 * n - 1 - i;
  endfunction
  function automatic int col_offset(input int i, input int n);
    int s;
    s = 0;
    for (int k = 0; k < i; k++) s += col_height(k, n);
    return s;
  endfunction
  function automatic int frame_bits(input int n);
    return n * n;
  endfunction
endpackage

// File: rtl/pp_column_shreg.sv
// pp_column_shreg: H-bit column shift register, newest bit at q[0]; ports clk, rst_n, clear, en, din, q
module pp_column_shreg #(
  parameter int H = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic         din,
  output logic [H-1:0] q
);
  if (H == 1) begin : g_one
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clear) q <= '0;
      else if (en) q <= din;
  end else begin : g_many
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clear) q <= '0;
      else if (en) q <= {q[H-2:0], din};
  end
endmodule

// File: rtl/pp_frame_loader.sv
// pp_frame_loader: loads N beats into triangular columns, waits LAT cycles, then holds the compressor result on a valid/ready handshake
// ports: clk, rst_n (async low), clear (sync flush); in_valid/in_ready/in_bits beat input; frame to compressor;
//        res_in from compressor; res_valid/res_ready/res_q result output
module pp_frame_loader import pp_frame_pkg::*; #(
  parameter int N     = 23,
  parameter int RES_W = 2 * N + 1,
  parameter int LAT   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*N-2:0]             in_bits,
  output logic [frame_bits(N)-1:0]   frame,
  input  logic [RES_W-1:0]           res_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [RES_W-1:0]           res_q
);
  localparam int COLS = 2 * N - 1;
  localparam int BW = $clog2(N + 1);
  localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wait_q, wait_d;
  logic resv_q, resv_d;
  logic [RES_W-1:0] res_d;
  logic shift_en;
  assign in_ready = state_q == FILL;
  assign res_valid = resv_q;
  assign shift_en = in_ready && in_valid;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int H = col_height(c, N);
    localparam int O = col_offset(c, N);
    pp_column_shreg #(.H(H)) u_col (
      .clk(clk), .rst_n(rst_n), .clear(clear), .en(shift_en), .din(in_bits[c]), .q(frame[O +: H])
    );
  end
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    wait_d = wait_q;
    resv_d = resv_q;
    res_d = res_q;
    case (state_q)
      FILL: if (in_valid) begin
        beat_d = (beat_q == BW'(N - 1)) ? '0 : beat_q + 1'b1;
        wait_d = (beat_q == BW'(N - 1)) ? '0 : wait_q;
        state_d = (beat_q == BW'(N - 1)) ? SETTLE : FILL;
      end
      SETTLE: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WW'(LAT)) begin
          res_d = res_in;
          resv_d = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: if (res_ready) begin
        resv_d = 1'b0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || clear) begin
      state_q <= FILL;
      beat_q <= '0;
      wait_q <= '0;
      resv_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      wait_q <= wait_d;
      resv_q <= resv_d;
      res_q <= res_d;
    end
endmodule
